// File: rtl/i2c_reg_master_pkg.sv
// i2c_reg_master_pkg
//   Shared types and constants for the I2C register-access master.
//   - state_t : transaction FSM states
//   - Q0..Q3  : quarter-phase encodings within one bit period
//   - DEV_WR / DEV_RD : R/W bit appended to the 7-bit device address
//   - scl_mid_high() : SCL released during Q1/Q2 of an ordinary bit
package i2c_reg_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DEVW,
    ST_ACK,
    ST_REG,
    ST_WDATA,
    ST_RSTART,
    ST_DEVR,
    ST_RDATA,
    ST_MNACK,
    ST_STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic DEV_WR = 1'b0;
  localparam logic DEV_RD = 1'b1;

  function automatic logic scl_mid_high(input logic [1:0] q);
    return (q == Q1) || (q == Q2);
  endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen
//   Bit-timing generator: a CLK_DIV divider producing one tick per quarter
//   period and a 2-bit quarter counter (Q0..Q3). Counters sit at zero while
//   i_en is low, so every transaction starts at Q0 of a fresh quarter.
//   Optional feature macro: I2C_CLK_STRETCH_EN -- when defined, the end of Q1
//   is held until the synchronised SCL line reads high (slave clock stretching,
//   no timeout).
// Ports
//   clk       in  system clock
//   rst_n     in  async active-low reset
//   i_en      in  run the divider (transaction active)
//   i_scl_s   in  synchronised SCL line sense
//   o_tick    out one-cycle pulse at the end of each quarter
//   o_quarter out current quarter (Q0..Q3)
module i2c_phase_gen
  import i2c_reg_master_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_scl_s,
  output logic       o_tick,
  output logic [1:0] o_quarter
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_quarter;
  logic          w_term;
  logic          w_hold;

  assign w_term = (r_cnt == TERM);

`ifdef I2C_CLK_STRETCH_EN
  // Park at terminal count of Q1 until the line really went high.
  assign w_hold = (r_quarter == Q1) && !i_scl_s;
`else
  // Fixed bit timing: the line sense plays no part.
  assign w_hold = i_scl_s & 1'b0;
`endif

  assign o_tick    = i_en && w_term && !w_hold;
  assign o_quarter = r_quarter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_quarter <= Q0;
    end else if (!i_en) begin
      r_cnt     <= '0;
      r_quarter <= Q0;
    end else if (o_tick) begin
      r_cnt     <= '0;
      r_quarter <= r_quarter + 2'd1;
    end else if (!w_term) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_reg_master.sv
// i2c_reg_master
//   Byte-level I2C initiator for single-register write/read transactions:
//   write = START dev+W, reg, data, STOP; read = START dev+W, reg, RSTART
//   dev+R, one data byte with master NACK, STOP. Open-drain via output
//   enables only (0 = pull low). Pad enables are registered so both lines
//   lag state/quarter by the same single cycle.
//   Optional feature macro: I2C_CLK_STRETCH_EN (see i2c_phase_gen).
// Ports
//   clk, rst (async active-low, deassert synchronised internally)
//   start/rnw/devAddr/regAddr/wrData : command, latched when accepted in IDLE
//   rdData : read byte, updated only by a successful read
//   busy/done/ackErr : status; done pulses once as STOP completes
//   scl_pad_i/sda_pad_i : line sense; scl_padoen_o/sda_padoen_o : line enables
//
// state     | meaning
// IDLE      | lines released, waiting for start
// START     | SDA falls while SCL high
// DEVW      | shift out devAddr + W
// ACK       | slave acknowledge slot, sampled at Q2
// REG       | shift out register address
// WDATA     | shift out write byte
// RSTART    | repeated start before the read address
// DEVR      | shift out devAddr + R
// RDATA     | shift in read byte at Q2
// MNACK     | master NACK (SDA released) ends the read
// STOP      | SDA rises while SCL high
module i2c_reg_master
  import i2c_reg_master_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rnw,
  input  logic [6:0] devAddr,
  input  logic [7:0] regAddr,
  input  logic [7:0] wrData,
  output logic [7:0] rdData,
  output logic       busy,
  output logic       done,
  output logic       ackErr,
  input  logic       scl_pad_i,
  output logic       scl_padoen_o,
  input  logic       sda_pad_i,
  output logic       sda_padoen_o
);

  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  logic [1:0] r_scl_sync, r_sda_sync;
  logic       w_scl_s, w_sda_s;

  state_t     r_state, w_state_nxt, r_last;
  logic       r_rnw;
  logic [6:0] r_dev;
  logic [7:0] r_reg, r_wdata, r_shift, r_rd_data;
  logic [2:0] r_bit;
  logic       r_ack_bit, r_ack_err, r_done;
  logic       r_scl_oe, r_sda_oe;
  logic       w_scl_oe, w_sda_oe;
  logic       w_tick, w_bit_end, w_sample, w_accept;
  logic [1:0] w_quarter;

  // Reset asserts asynchronously (lines released at once), releases on a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_pad_i};
      r_sda_sync <= {r_sda_sync[0], sda_pad_i};
    end
  end
  assign w_scl_s = r_scl_sync[1];
  assign w_sda_s = r_sda_sync[1];

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk       (clk),
    .rst_n     (w_rst_n),
    .i_en      (r_state != ST_IDLE),
    .i_scl_s   (w_scl_s),
    .o_tick    (w_tick),
    .o_quarter (w_quarter)
  );

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_bit_end = w_tick && (w_quarter == Q3);
  assign w_sample  = w_tick && (w_quarter == Q2);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scl_oe    = 1'b1;
    w_sda_oe    = 1'b1;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_START;
      ST_START: begin
        w_scl_oe = (w_quarter != Q3);
        w_sda_oe = (w_quarter == Q0) || (w_quarter == Q1);
        if (w_bit_end) w_state_nxt = ST_DEVW;
      end
      ST_RSTART: begin
        w_scl_oe = scl_mid_high(w_quarter);
        w_sda_oe = (w_quarter == Q0) || (w_quarter == Q1);
        if (w_bit_end) w_state_nxt = ST_DEVR;
      end
      ST_DEVW, ST_REG, ST_WDATA, ST_DEVR: begin
        w_scl_oe = scl_mid_high(w_quarter);
        w_sda_oe = r_shift[7];
        if (w_bit_end && r_bit == 3'd0) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_scl_oe = scl_mid_high(w_quarter);
        if (w_bit_end) begin
          if (r_ack_bit) begin
            w_state_nxt = ST_STOP;
          end else begin
            case (r_last)
              ST_DEVW: w_state_nxt = ST_REG;
              ST_REG:  w_state_nxt = r_rnw ? ST_RSTART : ST_WDATA;
              ST_DEVR: w_state_nxt = ST_RDATA;
              default: w_state_nxt = ST_STOP;
            endcase
          end
        end
      end
      ST_RDATA: begin
        w_scl_oe = scl_mid_high(w_quarter);
        if (w_bit_end && r_bit == 3'd0) w_state_nxt = ST_MNACK;
      end
      ST_MNACK: begin
        w_scl_oe = scl_mid_high(w_quarter);
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        w_scl_oe = (w_quarter != Q0);
        w_sda_oe = (w_quarter == Q2) || (w_quarter == Q3);
        if (w_bit_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rnw     <= 1'b0;
      r_dev     <= '0;
      r_reg     <= '0;
      r_wdata   <= '0;
      r_shift   <= '0;
      r_rd_data <= '0;
      r_bit     <= '0;
      r_last    <= ST_IDLE;
      r_ack_bit <= 1'b0;
      r_ack_err <= 1'b0;
      r_done    <= 1'b0;
      r_scl_oe  <= 1'b1;
      r_sda_oe  <= 1'b1;
    end else begin
      r_done   <= 1'b0;
      r_scl_oe <= w_scl_oe;
      r_sda_oe <= w_sda_oe;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_rnw     <= rnw;
          r_dev     <= devAddr;
          r_reg     <= regAddr;
          r_wdata   <= wrData;
          r_ack_err <= 1'b0;
        end
        ST_START: if (w_bit_end) begin
          r_shift <= {r_dev, DEV_WR};
          r_bit   <= 3'd7;
        end
        ST_RSTART: if (w_bit_end) begin
          r_shift <= {r_dev, DEV_RD};
          r_bit   <= 3'd7;
        end
        ST_DEVW, ST_REG, ST_WDATA, ST_DEVR: if (w_bit_end) begin
          r_shift <= {r_shift[6:0], 1'b0};
          r_bit   <= r_bit - 3'd1;
          if (r_bit == 3'd0) r_last <= r_state;
        end
        ST_ACK: begin
          if (w_sample) r_ack_bit <= w_sda_s;
          if (w_bit_end) begin
            r_bit <= 3'd7;
            if (r_ack_bit) r_ack_err <= 1'b1;
            else if (r_last == ST_DEVW) r_shift <= r_reg;
            else if (r_last == ST_REG && !r_rnw) r_shift <= r_wdata;
          end
        end
        ST_RDATA: begin
          if (w_sample)  r_shift <= {r_shift[6:0], w_sda_s};
          if (w_bit_end) r_bit   <= r_bit - 3'd1;
        end
        ST_MNACK: if (w_bit_end) r_rd_data <= r_shift;
        ST_STOP:  if (w_bit_end) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rdData       = r_rd_data;
  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign ackErr       = r_ack_err;
  assign scl_padoen_o = r_scl_oe;
  assign sda_padoen_o = r_sda_oe;

endmodule

// File: tb/tb_i2c_reg_master.sv
module tb_i2c_reg_master;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rnw = 1'b0;
  logic [6:0] devAddr = '0;
  logic [7:0] regAddr = '0;
  logic [7:0] wrData = '0;
  logic [7:0] rdData;
  logic       busy, done, ackErr;
  logic       scl_padoen_o, sda_padoen_o;
  logic       bus_scl, bus_sda;

  logic       s_scl_oe = 1'b1;
  logic       s_sda_oe = 1'b1;
  logic       s_clr = 1'b1;
  logic       stretch_en = 1'b0;

  assign bus_scl = scl_padoen_o & s_scl_oe;
  assign bus_sda = sda_padoen_o & s_sda_oe;

  always #5 clk = ~clk;

  i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .rnw(rnw), .devAddr(devAddr),
    .regAddr(regAddr), .wrData(wrData), .rdData(rdData), .busy(busy),
    .done(done), .ackErr(ackErr), .scl_pad_i(bus_scl), .scl_padoen_o(scl_padoen_o),
    .sda_pad_i(bus_sda), .sda_padoen_o(sda_padoen_o)
  );

  // Register slave model at address 0x3c, registers 0..7.
  logic [7:0] mem [0:7];
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         s_mode = 0, s_cnt = 0, s_next = 0, s_starts = 0, st_cnt = 0;
  int         hi_cnt = 0, hi_last = 0, hi_str = 0;
  logic [7:0] sh = '0, tx = '0, ptr = '0;
  logic       ack_drive = 1'b0, s_meas = 1'b0, s_str_done = 1'b0;

  always @(posedge clk) begin
    p_scl <= bus_scl;
    p_sda <= bus_sda;
    hi_cnt <= bus_scl ? hi_cnt + 1 : 0;
    if (p_scl && !bus_scl) begin
      hi_last <= hi_cnt;
      if (s_meas) begin hi_str <= hi_cnt; s_meas <= 1'b0; end
    end
    if (s_clr) begin
      mem[0] <= 8'h00; mem[1] <= 8'h00; mem[2] <= 8'h00; mem[3] <= 8'h00;
      mem[4] <= 8'h12; mem[5] <= 8'h34; mem[6] <= 8'h56; mem[7] <= 8'h78;
      s_mode <= 0; ack_drive <= 1'b0; s_sda_oe <= 1'b1; s_scl_oe <= 1'b1;
      st_cnt <= 0; s_str_done <= 1'b0;
    end else begin
      if (st_cnt > 0) begin
        st_cnt <= st_cnt - 1;
        if (st_cnt == 1) begin s_scl_oe <= 1'b1; s_meas <= 1'b1; end
      end
      if (p_scl && bus_scl && p_sda && !bus_sda) begin
        s_starts <= s_starts + 1; s_mode <= 1; s_cnt <= 0; ack_drive <= 1'b0; s_sda_oe <= 1'b1;
      end else if (p_scl && bus_scl && !p_sda && bus_sda) begin
        s_mode <= 0; ack_drive <= 1'b0; s_sda_oe <= 1'b1;
      end else if (!p_scl && bus_scl) begin
        if (!ack_drive && s_mode >= 1 && s_mode <= 3 && s_cnt < 8) begin
          sh <= {sh[6:0], bus_sda}; s_cnt <= s_cnt + 1;
        end else if (s_mode == 4) s_cnt <= s_cnt + 1;
      end else if (p_scl && !bus_scl) begin
        if (ack_drive) begin
          ack_drive <= 1'b0; s_cnt <= 0; s_mode <= s_next;
          if (s_next == 4) begin s_sda_oe <= tx[7]; tx <= tx << 1; end
          else s_sda_oe <= 1'b1;
        end else if (s_mode >= 1 && s_mode <= 3 && s_cnt == 8) begin
          case (s_mode)
            1: if (sh[7:1] == 7'h3c) begin
                 s_sda_oe <= 1'b0; ack_drive <= 1'b1;
                 if (sh[0]) begin s_next <= 4; tx <= mem[ptr[2:0]]; end
                 else s_next <= 2;
               end else s_mode <= 0;
            2: begin ptr <= sh; s_sda_oe <= 1'b0; ack_drive <= 1'b1; s_next <= 3; end
            default: begin
              mem[ptr[2:0]] <= sh; ptr <= ptr + 8'd1;
              s_sda_oe <= 1'b0; ack_drive <= 1'b1; s_next <= 3;
            end
          endcase
        end else if (s_mode == 4) begin
          if (s_cnt < 8) begin s_sda_oe <= tx[7]; tx <= tx << 1; end
          else if (s_cnt == 8) s_sda_oe <= 1'b1;
          else s_mode <= 0;
        end
        if (stretch_en && !s_str_done && !ack_drive && s_mode == 3 && s_cnt == 3) begin
          s_scl_oe <= 1'b0; st_cnt <= 50; s_str_done <= 1'b1;
        end
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic run_cmd(input logic r, input logic [6:0] d, input logic [7:0] ra,
                         input logic [7:0] wd, output int n_done);
    logic tmo;
    @(negedge clk);
    rnw = r; devAddr = d; regAddr = ra; wrData = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1'b1);
    n_done = 0; tmo = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin n_done++; tmo = 1'b0; break; end
    end
    if (tmo) bound_fail("done_timeout");
    else chk("busy_fall_with_done", busy, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
  endtask

  typedef struct {
    logic       rnw;
    logic [6:0] dev;
    logic [7:0] ra;
    logic [7:0] wd;
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_starts;
    logic [7:0] exp_mem;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   nd, st0;
    logic hit;
    vt[0] = '{1'b0, 7'h3c, 8'h00, 8'hA5, 1'b0, 8'h00, 1, 8'hA5};
    vt[1] = '{1'b1, 7'h3c, 8'h04, 8'h00, 1'b0, 8'h12, 2, 8'h00};
    vt[2] = '{1'b1, 7'h3c, 8'h00, 8'h00, 1'b0, 8'hA5, 2, 8'h00};
    vt[3] = '{1'b0, 7'h10, 8'h02, 8'h77, 1'b1, 8'hA5, 1, 8'h00};
    vt[4] = '{1'b1, 7'h10, 8'h05, 8'h00, 1'b1, 8'hA5, 1, 8'h00};
    vt[5] = '{1'b1, 7'h3c, 8'h07, 8'h00, 1'b0, 8'h78, 2, 8'h00};
    vt[6] = '{1'b0, 7'h3c, 8'h05, 8'hC3, 1'b0, 8'h78, 1, 8'hC3};
    vt[7] = '{1'b1, 7'h3c, 8'h05, 8'h00, 1'b0, 8'hC3, 2, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_scl_oe", scl_padoen_o, 1'b1);
    chk("rst_sda_oe", sda_padoen_o, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ackerr", ackErr, 1'b0);
    chk("rst_rddata", rdData, 8'h00);
    rst = 1'b1;
    s_clr = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      st0 = s_starts;
      run_cmd(vt[v].rnw, vt[v].dev, vt[v].ra, vt[v].wd, nd);
      chk($sformatf("v%0d_done_count", v), nd, 1);
      chk($sformatf("v%0d_ackerr", v), ackErr, vt[v].exp_err);
      chk($sformatf("v%0d_rddata", v), rdData, vt[v].exp_rd);
      chk($sformatf("v%0d_starts", v), s_starts - st0, vt[v].exp_starts);
      chk($sformatf("v%0d_scl_released", v), scl_padoen_o, 1'b1);
      chk($sformatf("v%0d_sda_released", v), sda_padoen_o, 1'b1);
      if (!vt[v].rnw) chk($sformatf("v%0d_slave_reg", v), mem[vt[v].ra[2:0]], vt[v].exp_mem);
    end
    chk("scl_high_time", hi_last, 2 * CLK_DIV);

    // Reset in the middle of the register-address byte.
    @(negedge clk);
    rnw = 1'b0; devAddr = 7'h3c; regAddr = 8'h03; wrData = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_mode == 2 && s_cnt == 4) begin hit = 1'b1; break; end
    end
    if (!hit) bound_fail("reach_reg_byte");
    #2 rst = 1'b0;
    #1;
    chk("midrst_scl_oe", scl_padoen_o, 1'b1);
    chk("midrst_sda_oe", sda_padoen_o, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_rddata", rdData, 8'h00);
    run_cmd(1'b0, 7'h3c, 8'h01, 8'h5A, nd);
    chk("postrst_done_count", nd, 1);
    chk("postrst_ackerr", ackErr, 1'b0);
    chk("postrst_reg1", mem[1], 8'h5A);
    chk("postrst_reg3_untouched", mem[3], 8'h00);

    // start held high across two back-to-back writes; mid-transfer input changes.
    @(negedge clk);
    rnw = 1'b0; devAddr = 7'h3c; regAddr = 8'h02; wrData = 8'h11; start = 1'b1;
    nd = 0;
    hit = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (i == 20) begin regAddr = 8'h03; wrData = 8'h22; end
      if (done) nd++;
      if (nd == 2) begin start = 1'b0; hit = 1'b1; break; end
    end
    start = 1'b0;
    if (!hit) bound_fail("b2b_two_dones");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("b2b_done_count", nd, 2);
    chk("b2b_reg2", mem[2], 8'h11);
    chk("b2b_reg3", mem[3], 8'h22);
    chk("b2b_idle", busy, 1'b0);

`ifdef I2C_CLK_STRETCH_EN
    stretch_en = 1'b1;
    run_cmd(1'b0, 7'h3c, 8'h06, 8'h96, nd);
    chk("stretch_done_count", nd, 1);
    chk("stretch_happened", s_str_done, 1'b1);
    chk("stretch_ackerr", ackErr, 1'b0);
    chk("stretch_reg6", mem[6], 8'h96);
    chk("stretch_high_time", hi_str, 2 * CLK_DIV);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
